fpu_addsub_issue: RTL and testbench

Issue and unpack stage in front of the combinational single-precision add/sub datapath. It accepts raw IEEE-754 binary32 operand pairs over a valid/ready handshake and resolves the rounding mode (static or dynamic from frm). It classifies each operand, unpacks sign/exponent/significand, and presents one registered, fully decoded operation per cycle on a valid/ready output. A 2-entry skid buffer (main + skid register) gives full throughput under output backpressure.

---
 rtl/fpu_addsub_issue_if.sv | 48 ++++
 rtl/fpu_addsub_issue.sv | 122 ++++++++++++
 tb/tb_fpu_addsub_issue.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_addsub_issue_if.sv
// Handshake and decoded-operand bundle between the issue logic, its
// upstream operand source and the downstream add/sub datapath.
interface fpu_addsub_issue_if;
  // upstream side
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        sub_op_i;
  logic [2:0]  rm_i;
  logic [2:0]  frm_i;
  logic        flush_i;
  // downstream side
  logic        out_valid_o;
  logic        out_ready_i;
  logic        sign_a_o;
  logic        sign_b_o;
  logic [7:0]  exp_a_o;
  logic [7:0]  exp_b_o;
  logic [23:0] sig_a_o;
  logic [23:0] sig_b_o;
  logic        is_zero_a_o;
  logic        is_zero_b_o;
  logic        is_inf_a_o;
  logic        is_inf_b_o;
  logic        is_nan_a_o;
  logic        is_nan_b_o;
  logic        is_signaling_o;
  logic        sub_op_o;
  logic [2:0]  rm_o;
  logic        illegal_rm_o;

  // the issue stage itself
  modport slave (
    input  in_valid_i, op_a_i, op_b_i, sub_op_i, rm_i, frm_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, sign_a_o, sign_b_o, exp_a_o, exp_b_o,
           sig_a_o, sig_b_o, is_zero_a_o, is_zero_b_o, is_inf_a_o, is_inf_b_o,
           is_nan_a_o, is_nan_b_o, is_signaling_o, sub_op_o, rm_o, illegal_rm_o
  );

  // whoever drives operands in and consumes decoded ops
  modport master (
    output in_valid_i, op_a_i, op_b_i, sub_op_i, rm_i, frm_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, sign_a_o, sign_b_o, exp_a_o, exp_b_o,
           sig_a_o, sig_b_o, is_zero_a_o, is_zero_b_o, is_inf_a_o, is_inf_b_o,
           is_nan_a_o, is_nan_b_o, is_signaling_o, sub_op_o, rm_o, illegal_rm_o
  );
endinterface

// File: rtl/fpu_addsub_issue.sv
// Issue/unpack stage for the binary32 add/sub datapath: decodes raw operand
// pairs, resolves the rounding mode and holds up to two decoded ops in a
// main + skid register pair so that backpressure never costs throughput.
module fpu_addsub_issue #(
  parameter logic [2:0] RM_DYN          = 3'b111,
  parameter bit         RESET_DATA_ZERO = 1'b1
) (
  input logic            clk_i,
  input logic            reset_i,
  fpu_addsub_issue_if.slave bus
);

  typedef struct packed {
    logic        sign_a;
    logic        sign_b;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [23:0] sig_a;
    logic [23:0] sig_b;
    logic        is_zero_a;
    logic        is_zero_b;
    logic        is_inf_a;
    logic        is_inf_b;
    logic        is_nan_a;
    logic        is_nan_b;
    logic        is_signaling;
    logic        sub_op;
    logic [2:0]  rm;
    logic        illegal_rm;
  } op_t;

  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic [2:0]  rm_res;
  op_t         in_op;
  op_t         main_q, skid_q;
  logic        main_v, skid_v;
  logic        accept, transfer;

  assign exp_a  = bus.op_a_i[30:23];
  assign exp_b  = bus.op_b_i[30:23];
  assign frac_a = bus.op_a_i[22:0];
  assign frac_b = bus.op_b_i[22:0];
  assign rm_res = (bus.rm_i == RM_DYN) ? bus.frm_i : bus.rm_i;

  // Ready depends only on registered occupancy, never on out_ready_i.
  assign bus.in_ready_o = !skid_v && !reset_i;
  assign accept         = bus.in_valid_i && bus.in_ready_o;
  assign transfer       = main_v && bus.out_ready_i;

  // Classify and unpack the offered operand pair.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path can infer a latch.
    in_op              = '0;
    in_op.sign_a       = bus.op_a_i[31];
    in_op.sign_b       = bus.op_b_i[31];
    in_op.exp_a        = exp_a;
    in_op.exp_b        = exp_b;
    in_op.sig_a        = {exp_a != 8'h00, frac_a};
    in_op.sig_b        = {exp_b != 8'h00, frac_b};
    in_op.is_zero_a    = (exp_a == 8'h00) && (frac_a == '0);
    in_op.is_zero_b    = (exp_b == 8'h00) && (frac_b == '0);
    in_op.is_inf_a     = (exp_a == 8'hFF) && (frac_a == '0);
    in_op.is_inf_b     = (exp_b == 8'hFF) && (frac_b == '0);
    in_op.is_nan_a     = (exp_a == 8'hFF) && (frac_a != '0);
    in_op.is_nan_b     = (exp_b == 8'hFF) && (frac_b != '0);
    // A NaN with a clear quiet bit is signaling.
    in_op.is_signaling = (in_op.is_nan_a && !frac_a[22]) || (in_op.is_nan_b && !frac_b[22]);
    in_op.sub_op       = bus.sub_op_i;
    in_op.rm           = rm_res;
    in_op.illegal_rm   = rm_res >= 3'b101;
  end

  // Two-entry FIFO: main feeds the output, skid absorbs one op under backpressure.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      // NOTE: payload registers only need clearing when zeroed outputs after reset are wanted; the valid bits alone make the FIFO safe.
      if (RESET_DATA_ZERO) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else if (bus.flush_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (transfer && skid_v) begin
      main_q <= skid_q;
      skid_v <= accept;
      if (accept) skid_q <= in_op;
    end else if (transfer) begin
      main_v <= accept;
      if (accept) main_q <= in_op;
    end else if (accept && main_v) begin
      skid_q <= in_op;
      skid_v <= 1'b1;
    end else if (accept) begin
      main_q <= in_op;
      main_v <= 1'b1;
    end
  end

  assign bus.out_valid_o    = main_v;
  assign bus.sign_a_o       = main_q.sign_a;
  assign bus.sign_b_o       = main_q.sign_b;
  assign bus.exp_a_o        = main_q.exp_a;
  assign bus.exp_b_o        = main_q.exp_b;
  assign bus.sig_a_o        = main_q.sig_a;
  assign bus.sig_b_o        = main_q.sig_b;
  assign bus.is_zero_a_o    = main_q.is_zero_a;
  assign bus.is_zero_b_o    = main_q.is_zero_b;
  assign bus.is_inf_a_o     = main_q.is_inf_a;
  assign bus.is_inf_b_o     = main_q.is_inf_b;
  assign bus.is_nan_a_o     = main_q.is_nan_a;
  assign bus.is_nan_b_o     = main_q.is_nan_b;
  assign bus.is_signaling_o = main_q.is_signaling;
  assign bus.sub_op_o       = main_q.sub_op;
  assign bus.rm_o           = main_q.rm;
  assign bus.illegal_rm_o   = main_q.illegal_rm;

endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Self-checking bench for fpu_addsub_issue: a queue-based reference model of
// the two-entry issue FIFO plus an arithmetic operand classifier, compared
// against the DUT every cycle, with literal checks from hand-worked cases.
module tb_fpu_addsub_issue;

  typedef struct packed {
    logic        sign_a;
    logic        sign_b;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [23:0] sig_a;
    logic [23:0] sig_b;
    logic        is_zero_a;
    logic        is_zero_b;
    logic        is_inf_a;
    logic        is_inf_b;
    logic        is_nan_a;
    logic        is_nan_b;
    logic        is_signaling;
    logic        sub_op;
    logic [2:0]  rm;
    logic        illegal_rm;
  } exp_op_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;
  exp_op_t model_q[$];

  fpu_addsub_issue_if bus ();

  fpu_addsub_issue dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Classification from field arithmetic: exponent is bits 30..23, fraction the low 23 bits.
  function automatic exp_op_t model_decode(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub, input logic [2:0] rm, input logic [2:0] frm);
    exp_op_t o;
    int ea, eb, fa, fb, rmr;
    ea  = int'(a >> 23) % 256;
    eb  = int'(b >> 23) % 256;
    fa  = int'(a % 32'h0080_0000);
    fb  = int'(b % 32'h0080_0000);
    rmr = (rm == 3'd7) ? int'(frm) : int'(rm);
    o.sign_a       = a >= 32'h8000_0000;
    o.sign_b       = b >= 32'h8000_0000;
    o.exp_a        = 8'(ea);
    o.exp_b        = 8'(eb);
    o.sig_a        = 24'((ea != 0 ? 32'h0080_0000 : 0) + fa);
    o.sig_b        = 24'((eb != 0 ? 32'h0080_0000 : 0) + fb);
    o.is_zero_a    = (ea == 0) && (fa == 0);
    o.is_zero_b    = (eb == 0) && (fb == 0);
    o.is_inf_a     = (ea == 255) && (fa == 0);
    o.is_inf_b     = (eb == 255) && (fb == 0);
    o.is_nan_a     = (ea == 255) && (fa != 0);
    o.is_nan_b     = (eb == 255) && (fb != 0);
    o.is_signaling = (o.is_nan_a && fa < 32'h0040_0000) || (o.is_nan_b && fb < 32'h0040_0000);
    o.sub_op       = sub;
    o.rm           = 3'(rmr);
    o.illegal_rm   = rmr >= 5;
    return o;
  endfunction

  function automatic exp_op_t dut_op();
    exp_op_t o;
    o.sign_a       = bus.sign_a_o;
    o.sign_b       = bus.sign_b_o;
    o.exp_a        = bus.exp_a_o;
    o.exp_b        = bus.exp_b_o;
    o.sig_a        = bus.sig_a_o;
    o.sig_b        = bus.sig_b_o;
    o.is_zero_a    = bus.is_zero_a_o;
    o.is_zero_b    = bus.is_zero_b_o;
    o.is_inf_a     = bus.is_inf_a_o;
    o.is_inf_b     = bus.is_inf_b_o;
    o.is_nan_a     = bus.is_nan_a_o;
    o.is_nan_b     = bus.is_nan_b_o;
    o.is_signaling = bus.is_signaling_o;
    o.sub_op       = bus.sub_op_o;
    o.rm           = bus.rm_o;
    o.illegal_rm   = bus.illegal_rm_o;
    return o;
  endfunction

  // Reference model: a FIFO of capacity two, updated from the inputs seen at each edge.
  always @(posedge clk) begin
    bit acc, xfer;
    acc  = bus.in_valid_i && (model_q.size() < 2) && !reset;
    xfer = (model_q.size() > 0) && bus.out_ready_i;
    if (reset || bus.flush_i) begin
      model_q.delete();
    end else begin
      if (xfer) void'(model_q.pop_front());
      if (acc) model_q.push_back(model_decode(bus.op_a_i, bus.op_b_i, bus.sub_op_i, bus.rm_i, bus.frm_i));
    end
    cmp_en <= 1'b1;
  end

  // Compare process: handshake and head-of-queue payload every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("out_valid", 128'(bus.out_valid_o), 128'(model_q.size() > 0));
      check("in_ready", 128'(bus.in_ready_o), 128'((model_q.size() < 2) && !reset));
      if (model_q.size() > 0) check("decoded_op", 128'(dut_op()), 128'(model_q[0]));
    end
  end

  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [2:0] rm, input logic [2:0] frm);
    bus.op_a_i   = a;
    bus.op_b_i   = b;
    bus.sub_op_i = sub;
    bus.rm_i     = rm;
    bus.frm_i    = frm;
  endtask

  // Offer one op and wait (bounded) until the edge that accepts it; returns at edge+#1.
  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [2:0] rm, input logic [2:0] frm);
    bit done;
    bit rdy;
    done = 1'b0;
    set_op(a, b, sub, rm, frm);
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      rdy = bus.in_ready_o;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    bus.in_valid_i = 1'b0;
    if (!done) check("push_timeout", 128'(0), 128'(1));
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r = {r[31], 31'h0};
      1: r = {r[31], 8'hFF, 23'h0};
      2: r = {r[31], 8'hFF, 1'b1, r[21:0]};
      3: r = {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
      4: r = {r[31], 8'h00, r[22:0]};
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.flush_i     = 1'b0;
    set_op('0, '0, 1'b0, 3'b000, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 128'(bus.out_valid_o), 128'(0));
    check("reset_in_ready", 128'(bus.in_ready_o), 128'(1));
    check("reset_data_zero", 128'(dut_op()), 128'(0));
    @(posedge clk);
    #1;

    // 1.0 + 2.0
    push_op(32'h3F80_0000, 32'h4000_0000, 1'b0, 3'b000, 3'b000);
    @(negedge clk);
    check("t1_valid", 128'(bus.out_valid_o), 128'(1));
    check("t1_exp_a", 128'(bus.exp_a_o), 128'(8'h7F));
    check("t1_sig_a", 128'(bus.sig_a_o), 128'(24'h80_0000));
    check("t1_exp_b", 128'(bus.exp_b_o), 128'(8'h80));
    check("t1_sig_b", 128'(bus.sig_b_o), 128'(24'h80_0000));
    check("t1_flags", 128'({bus.is_zero_a_o, bus.is_zero_b_o, bus.is_inf_a_o, bus.is_inf_b_o,
                            bus.is_nan_a_o, bus.is_nan_b_o, bus.is_signaling_o}), 128'(0));
    @(posedge clk);
    #1;

    // sNaN and -inf
    push_op(32'h7FA0_0000, 32'hFF80_0000, 1'b1, 3'b001, 3'b000);
    @(negedge clk);
    check("t2_nan_a", 128'(bus.is_nan_a_o), 128'(1));
    check("t2_signaling", 128'(bus.is_signaling_o), 128'(1));
    check("t2_inf_b", 128'(bus.is_inf_b_o), 128'(1));
    check("t2_sign_b", 128'(bus.sign_b_o), 128'(1));
    check("t2_sub_op", 128'(bus.sub_op_o), 128'(1));
    @(posedge clk);
    #1;

    // quiet NaN alone is not signaling
    push_op(32'h7FC0_0000, 32'h3F80_0000, 1'b0, 3'b000, 3'b000);
    @(negedge clk);
    check("t3_nan_a", 128'(bus.is_nan_a_o), 128'(1));
    check("t3_signaling", 128'(bus.is_signaling_o), 128'(0));
    @(posedge clk);
    #1;

    // smallest subnormal and -0
    push_op(32'h0000_0001, 32'h8000_0000, 1'b0, 3'b000, 3'b000);
    @(negedge clk);
    check("t4_sig_a", 128'(bus.sig_a_o), 128'(24'h00_0001));
    check("t4_exp_a", 128'(bus.exp_a_o), 128'(0));
    check("t4_zero_a", 128'(bus.is_zero_a_o), 128'(0));
    check("t4_zero_b", 128'(bus.is_zero_b_o), 128'(1));
    check("t4_sign_b", 128'(bus.sign_b_o), 128'(1));
    @(posedge clk);
    #1;

    // rounding-mode resolution
    push_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'b111, 3'b010);
    @(negedge clk);
    check("t5_rm_dyn", 128'(bus.rm_o), 128'(3'b010));
    check("t5_rm_legal", 128'(bus.illegal_rm_o), 128'(0));
    @(posedge clk);
    #1;
    push_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'b111, 3'b101);
    @(negedge clk);
    check("t6_rm_dyn_bad", 128'(bus.rm_o), 128'(3'b101));
    check("t6_rm_illegal", 128'(bus.illegal_rm_o), 128'(1));
    @(posedge clk);
    #1;
    push_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'b110, 3'b000);
    @(negedge clk);
    check("t7_rm_illegal", 128'(bus.illegal_rm_o), 128'(1));
    @(posedge clk);
    #1;

    // four-op stream against three cycles of backpressure
    bus.out_ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          push_op(32'h4000_0000 + 32'(i), 32'h4040_0000 + 32'(i << 4), i[0], 3'(i), 3'b000);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("stream_full_ready", 128'(bus.in_ready_o), 128'(0));
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // flush with two held ops and an op offered in the flush cycle
    bus.out_ready_i = 1'b0;
    push_op(32'h4100_0000, 32'h4110_0000, 1'b0, 3'b000, 3'b000);
    push_op(32'h4120_0000, 32'h4130_0000, 1'b0, 3'b000, 3'b000);
    set_op(32'h4140_0000, 32'h4150_0000, 1'b1, 3'b001, 3'b000);
    bus.in_valid_i = 1'b1;
    bus.flush_i    = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 128'(bus.out_valid_o), 128'(0));
    check("flush_in_ready", 128'(bus.in_ready_o), 128'(1));
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("flush_no_ghost", 128'(bus.out_valid_o), 128'(0));
    @(posedge clk);
    #1;

    // reset mid-stream
    bus.out_ready_i = 1'b0;
    push_op(32'h4200_0000, 32'h4210_0000, 1'b0, 3'b000, 3'b000);
    push_op(32'h4220_0000, 32'h4230_0000, 1'b0, 3'b000, 3'b000);
    set_op(32'h4240_0000, 32'h4250_0000, 1'b0, 3'b000, 3'b000);
    bus.in_valid_i = 1'b1;
    reset          = 1'b1;
    @(negedge clk);
    check("rst_in_ready_low", 128'(bus.in_ready_o), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    reset          = 1'b0;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 128'(bus.out_valid_o), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready_o), 128'(1));
    check("rst_data_zero", 128'(dut_op()), 128'(0));
    @(posedge clk);
    #1;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      set_op(rand_fp(), rand_fp(), 1'($urandom), 3'($urandom), 3'($urandom));
      bus.in_valid_i  = $urandom_range(0, 9) < 7;
      bus.out_ready_i = $urandom_range(0, 9) < 6;
      bus.flush_i     = $urandom_range(0, 49) == 0;
      reset           = $urandom_range(0, 299) == 0;
      @(posedge clk);
      #1;
    end
    reset          = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.flush_i    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
